// File: rtl/code_pkg.sv
// Shared definitions for the dual event counter.
//   CODE_WIDTH : default width of each event counter
//   code_cnt_t : counter value type at the default width
package code_pkg;

  localparam int CODE_WIDTH = 64;

  typedef logic [CODE_WIDTH-1:0] code_cnt_t;

endpackage

// File: rtl/code_counter.sv
// Single event counter: synchronous-reset register plus incrementer.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high clear (has priority over Inc)
//   Inc   : increment strobe, adds 1 on the next rising edge
//   Q     : registered count, wraps modulo 2^WIDTH
module code_counter
  import code_pkg::*;
#(
  parameter int WIDTH = CODE_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Inc,
  output logic [WIDTH-1:0] Q
);

  // Initialiser gives a defined value before the first reset.
  logic [WIDTH-1:0] count = '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (Inc) begin
      // Natural modulo-2^WIDTH wrap; no saturation.
      count <= count + WIDTH'(1);
    end
  end

  assign Q = count;

endmodule

// File: rtl/code.sv
// Dual event counter with a selector. Each enabled cycle is steered by Slt
// to exactly one of two counters.
// Ports:
//   Clk     : rising-edge clock, single domain
//   Reset   : synchronous, active-high; clears both counters
//   Slt     : 0 -> count into Output0, 1 -> count into Output1
//   En      : count enable; 0 holds both counters
//   Output0 : counter 0 value, registered
//   Output1 : counter 1 value, registered
module code
  import code_pkg::*;
#(
  parameter int WIDTH = CODE_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);

  logic inc0;
  logic inc1;

  // Strobes are mutually exclusive, so the two counters never step together.
  assign inc0 = En & ~Slt;
  assign inc1 = En &  Slt;

  code_counter #(.WIDTH(WIDTH)) u_cnt0 (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (inc0),
    .Q     (Output0)
  );

  code_counter #(.WIDTH(WIDTH)) u_cnt1 (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (inc1),
    .Q     (Output1)
  );

endmodule

// File: tb/tb_code.sv
// Directed bench for the dual event counter. A default-width instance and an
// 8-bit instance share the same stimulus; the 8-bit one exposes wrap-around.
module tb_code;
  import code_pkg::*;

  // ---------------- clock / reset ----------------
  logic      Clk = 1'b0;
  logic      Reset = 1'b0;
  logic      Slt = 1'b0;
  logic      En = 1'b0;
  code_cnt_t out0;
  code_cnt_t out1;
  logic [7:0] s_out0;
  logic [7:0] s_out1;

  always #5 Clk = ~Clk;

  code dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Slt     (Slt),
    .En      (En),
    .Output0 (out0),
    .Output1 (out1)
  );

  code #(.WIDTH(8)) dut_w8 (
    .Clk     (Clk),
    .Reset   (Reset),
    .Slt     (Slt),
    .En      (En),
    .Output0 (s_out0),
    .Output1 (s_out1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge that consumed them.
  task automatic drive(input logic r, input logic e, input logic s);
    @(negedge Clk);
    Reset = r;
    En    = e;
    Slt   = s;
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] e0;
    logic [63:0] e1;

    // Power-up value, before any reset or edge.
    #1;
    chk("powerup_o0", out0, 64'd0);
    chk("powerup_o1", out1, 64'd0);

    apply_reset();
    chk("reset_o0", out0, 64'd0);
    chk("reset_o1", out1, 64'd0);

    // Idle: En=0, Slt toggling.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, i[0]);
      chk("idle_o0", out0, 64'd0);
      chk("idle_o1", out1, 64'd0);
    end

    // Alternating: Slt = 0,1,0,1,... with En=1. Expected pairs {o0,o1}.
    exp_q = '{64'd1, 64'd0, 64'd1, 64'd1, 64'd2, 64'd1, 64'd2, 64'd2, 64'd3, 64'd2,
              64'd3, 64'd3, 64'd4, 64'd3, 64'd4, 64'd4, 64'd5, 64'd4, 64'd5, 64'd5};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, i[0]);
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      chk("alt_o0", out0, e0);
      chk("alt_o1", out1, e1);
    end

    // Steady select from a clean start.
    apply_reset();
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1);
    chk("steady1_o1", out1, 64'd7);
    chk("steady1_o0", out0, 64'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
    chk("steady0_o0", out0, 64'd3);
    chk("steady0_o1", out1, 64'd7);

    // Hold with nonzero counts.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("hold_o0", out0, 64'd3);
    chk("hold_o1", out1, 64'd7);

    // Synchronous reset held for 3 edges while En=1.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, i[0]);
      chk("rst_hold_o0", out0, 64'd0);
      chk("rst_hold_o1", out1, 64'd0);
    end
    drive(1'b0, 1'b1, 1'b0);
    chk("rst_release_o0", out0, 64'd1);
    chk("rst_release_o1", out1, 64'd0);
    drive(1'b0, 1'b1, 1'b1);
    chk("pre_prio_o1", out1, 64'd1);

    // Reset priority over En=1, Slt=1.
    drive(1'b1, 1'b1, 1'b1);
    chk("prio_o0", out0, 64'd0);
    chk("prio_o1", out1, 64'd0);

    // Wrap on the 8-bit instance.
    drive(1'b0, 1'b1, 1'b1);
    chk("w8_pre_o1", {56'd0, s_out1}, 64'd1);
    for (int i = 0; i < 255; i++) drive(1'b0, 1'b1, 1'b0);
    chk("w8_full_o0", {56'd0, s_out0}, 64'd255);
    chk("w64_255_o0", out0, 64'd255);
    drive(1'b0, 1'b1, 1'b0);
    chk("w8_wrap_o0", {56'd0, s_out0}, 64'd0);
    chk("w8_wrap_o1", {56'd0, s_out1}, 64'd1);
    chk("w64_256_o0", out0, 64'd256);
    chk("w64_o1", out1, 64'd1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
